// File: rtl/dw_div_seq_hs_if.sv
// Operand/result handshake bundle for the sequential divider.
// The slave side is the divider; the master side is the producer/consumer.
interface dw_div_seq_hs_if #(
   parameter int A_WIDTH = 32,
   parameter int B_WIDTH = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [A_WIDTH-1:0] a;
   logic [B_WIDTH-1:0] b;
   logic               out_valid;
   logic               out_ready;
   logic [A_WIDTH-1:0] quotient;
   logic [B_WIDTH-1:0] remainder;
   logic               divide_by_0;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, quotient, remainder, divide_by_0
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, quotient, remainder, divide_by_0
   );
endinterface

// File: rtl/dw_div_seq_hs.sv
// Sequential radix-2 non-restoring divider, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module dw_div_seq_hs #(
   parameter int A_WIDTH  = 32,
   parameter int B_WIDTH  = 16,
   parameter int TC_MODE  = 0,
   parameter int REM_MODE = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clear,
   dw_div_seq_hs_if.slave  dv
);

   localparam int CW = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [CW-1:0]              r_cnt;

   logic                       w_in_ready;
   logic                       w_out_valid;
   logic                       w_accept;
   logic                       w_step;
   logic                       w_fix;

   logic                       r_sa;
   logic                       r_sb;
   logic                       r_bz;
   logic [B_WIDTH-1:0]         r_a_lo;
   logic [B_WIDTH-1:0]         r_bmag;
   logic [A_WIDTH-1:0]         r_q;
   logic signed [B_WIDTH:0]    r_p;

   logic                       w_sa;
   logic                       w_sb;
   logic [A_WIDTH-1:0]         w_amag;
   logic [B_WIDTH-1:0]         w_bmag;
   logic signed [B_WIDTH:0]    w_b_ext;
   logic signed [B_WIDTH:0]    w_p_sh;
   logic signed [B_WIDTH:0]    w_p_nxt;
   logic [B_WIDTH-1:0]         w_rmag;

   logic [A_WIDTH-1:0]         r_quo;
   logic [B_WIDTH-1:0]         r_rem;
   logic                       r_dz;

   function automatic logic [A_WIDTH-1:0] f_quo_sign(input logic [A_WIDTH-1:0] mag,
                                                     input logic sa, input logic sb);
      logic [A_WIDTH-1:0] res;
      res = (sa ^ sb) ? -mag : mag;
      return res;
   endfunction

   // Remainder takes the sign of a; modulus takes the sign of b. Zero stays zero.
   function automatic logic [B_WIDTH-1:0] f_rem_sign(input logic [B_WIDTH-1:0] mag,
                                                     input logic [B_WIDTH-1:0] bmag,
                                                     input logic sa, input logic sb);
      logic [B_WIDTH-1:0] res;
      logic [B_WIDTH-1:0] bs;
      bs  = sb ? -bmag : bmag;
      res = mag;
      if (mag != '0) begin
         if (REM_MODE != 0) begin
            res = sa ? -mag : mag;
         end else begin
            case ({sa, sb})
               2'b01:   res = bs + mag;
               2'b10:   res = bs - mag;
               2'b11:   res = -mag;
               default: res = mag;
            endcase
         end
      end
      return res;
   endfunction

   function automatic logic [A_WIDTH-1:0] f_dz_quo(input logic sa);
      logic [A_WIDTH-1:0] res;
      if (TC_MODE == 0)
         res = '1;
      else
         res = sa ? {1'b1, {(A_WIDTH-1){1'b0}}} : {1'b0, {(A_WIDTH-1){1'b1}}};
      return res;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (dv.in_valid)  w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == '0)  w_state_nxt = S_FIX;
            S_FIX:                     w_state_nxt = S_DONE;
            S_DONE:  if (dv.out_ready) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_fix       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            w_accept   = dv.in_valid & ~i_clear;
         end
         S_CALC:  w_step      = ~i_clear;
         S_FIX:   w_fix       = ~i_clear;
         S_DONE:  w_out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_cnt <= '0;
      else if (w_accept) r_cnt <= CW'(A_WIDTH - 1);
      else if (w_step)   r_cnt <= r_cnt - CW'(1);
   end

   // Operand capture: magnitudes only when operands are two's complement
   assign w_sa    = (TC_MODE != 0) && dv.a[A_WIDTH-1];
   assign w_sb    = (TC_MODE != 0) && dv.b[B_WIDTH-1];
   assign w_amag  = w_sa ? -dv.a : dv.a;
   assign w_bmag  = w_sb ? -dv.b : dv.b;

   // Iteration: partial remainder wraps modulo 2^(B_WIDTH+1); the true value always fits
   assign w_b_ext = $signed({1'b0, r_bmag});
   assign w_p_sh  = $signed({r_p[B_WIDTH-1:0], r_q[A_WIDTH-1]});
   assign w_p_nxt = r_p[B_WIDTH] ? (w_p_sh + w_b_ext) : (w_p_sh - w_b_ext);

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_sa   <= w_sa;
         r_sb   <= w_sb;
         r_bz   <= (dv.b == '0);
         r_a_lo <= dv.a[B_WIDTH-1:0];
         r_bmag <= w_bmag;
         r_q    <= w_amag;
         r_p    <= '0;
      end else if (w_step) begin
         r_p    <= w_p_nxt;
         r_q    <= {r_q[A_WIDTH-2:0], ~w_p_nxt[B_WIDTH]};
      end
   end

   // Correction: a negative final partial remainder is restored by one add of |b|
   assign w_rmag = r_p[B_WIDTH] ? (r_p[B_WIDTH-1:0] + r_bmag) : r_p[B_WIDTH-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_quo <= '0;
         r_rem <= '0;
         r_dz  <= 1'b0;
      end else if (w_fix) begin
         r_dz <= r_bz;
         if (r_bz) begin
            r_quo <= f_dz_quo(r_sa);
            r_rem <= r_a_lo;
         end else begin
            r_quo <= f_quo_sign(r_q, r_sa, r_sb);
            r_rem <= f_rem_sign(w_rmag, r_bmag, r_sa, r_sb);
         end
      end
   end

   assign dv.in_ready    = w_in_ready;
   assign dv.out_valid   = w_out_valid;
   assign dv.quotient    = r_quo;
   assign dv.remainder   = r_rem;
   assign dv.divide_by_0 = r_dz;

endmodule

// File: tb/tb_dw_div_seq_hs.sv
// Bench for dw_div_seq_hs: three instances (unsigned, signed remainder, signed modulus)
// share one operand stream and are compared against an arithmetic reference model.
module tb_dw_div_seq_hs;
   localparam int AW = 32;
   localparam int BW = 16;
   localparam int LAT = AW + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid;
   logic          out_ready;
   logic [AW-1:0] a;
   logic [BW-1:0] b;

   dw_div_seq_hs_if #(.A_WIDTH(AW), .B_WIDTH(BW)) if_u ();
   dw_div_seq_hs_if #(.A_WIDTH(AW), .B_WIDTH(BW)) if_r ();
   dw_div_seq_hs_if #(.A_WIDTH(AW), .B_WIDTH(BW)) if_m ();

   assign if_u.in_valid = in_valid;  assign if_u.out_ready = out_ready;
   assign if_u.a = a;                assign if_u.b = b;
   assign if_r.in_valid = in_valid;  assign if_r.out_ready = out_ready;
   assign if_r.a = a;                assign if_r.b = b;
   assign if_m.in_valid = in_valid;  assign if_m.out_ready = out_ready;
   assign if_m.a = a;                assign if_m.b = b;

   dw_div_seq_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .TC_MODE(0), .REM_MODE(1)) u_u (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .dv(if_u.slave));
   dw_div_seq_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .TC_MODE(1), .REM_MODE(1)) u_r (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .dv(if_r.slave));
   dw_div_seq_hs #(.A_WIDTH(AW), .B_WIDTH(BW), .TC_MODE(1), .REM_MODE(0)) u_m (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .dv(if_m.slave));

   logic [2:0]    ov, ir, dzo;
   logic [AW-1:0] q_o [3];
   logic [BW-1:0] r_o [3];
   assign ov  = {if_m.out_valid, if_r.out_valid, if_u.out_valid};
   assign ir  = {if_m.in_ready, if_r.in_ready, if_u.in_ready};
   assign dzo = {if_m.divide_by_0, if_r.divide_by_0, if_u.divide_by_0};
   assign q_o[0] = if_u.quotient;  assign r_o[0] = if_u.remainder;
   assign q_o[1] = if_r.quotient;  assign r_o[1] = if_r.remainder;
   assign q_o[2] = if_m.quotient;  assign r_o[2] = if_m.remainder;

   int n_tests = 0;
   int n_fail  = 0;

   logic [AW-1:0] eq  [3];
   logic [BW-1:0] er  [3];
   logic          edz [3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // cfg 0: unsigned; cfg 1: signed, remainder; cfg 2: signed, modulus
   function automatic void model(input int cfg, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                                 output logic [AW-1:0] q, output logic [BW-1:0] r, output logic dz);
      longint sa, sb, qq, rr;
      dz = (bv == '0);
      if (bv == '0) begin
         r = av[BW-1:0];
         if (cfg == 0)      q = '1;
         else if (av[AW-1]) q = 32'h8000_0000;
         else               q = 32'h7FFF_FFFF;
      end else if (cfg == 0) begin
         q = av / AW'(bv);
         r = BW'(av % AW'(bv));
      end else begin
         sa = longint'($signed(av));
         sb = longint'($signed(bv));
         qq = sa / sb;
         rr = sa % sb;
         if (cfg == 2 && rr != 0 && ((rr < 0) != (sb < 0))) rr = rr + sb;
         q = AW'(qq);
         r = BW'(rr);
      end
   endfunction

   task automatic check_results(input string tag);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("%s_q%0d", tag, c),  q_o[c],  eq[c]);
         chk($sformatf("%s_r%0d", tag, c),  r_o[c],  er[c]);
         chk($sformatf("%s_dz%0d", tag, c), dzo[c], edz[c]);
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      while (ir != 3'b111 && k < 100) begin @(negedge clk); k++; end
      chk("ready_before_op", ir, 3'b111);
   endtask

   task automatic do_op(input logic [AW-1:0] av, input logic [BW-1:0] bv, input int stall);
      int k;
      for (int c = 0; c < 3; c++) model(c, av, bv, eq[c], er[c], edz[c]);
      wait_ready();
      a = av; b = bv; in_valid = 1'b1; out_ready = (stall == 0);
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = BW'($urandom);
      chk("busy_in_ready", ir, 3'b000);
      k = 0;
      while (ov == 3'b000 && k < 60) begin @(negedge clk); k++; end
      chk("latency", k, LAT);
      chk("out_valid_all", ov, 3'b111);
      check_results("res");
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_hold", {ov, ir, q_o[0], r_o[2], dzo},
             {3'b111, 3'b000, eq[0], er[2], edz[2], edz[1], edz[0]});
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_handshake", {ir, ov}, {3'b111, 3'b000});
      chk("result_hold", {q_o[1], r_o[1]}, {eq[1], er[1]});
   endtask

   logic [AW-1:0] ra;
   logic [BW-1:0] rb;
   logic          saw_ov;

   initial begin
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", ir, 3'b111);
      chk("rst_out_valid", ov, 3'b000);
      chk("rst_dz", dzo, 3'b000);
      chk("rst_results", {q_o[0], r_o[0], q_o[1], r_o[2]}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(32'd100, 16'd7, 0);
      do_op(32'hFFFF_FFF9, 16'd2, 0);
      do_op(32'd7, 16'hFFFE, 0);
      do_op(32'd5, 16'd0, 0);
      do_op(32'hFFFF_FFFB, 16'd0, 0);
      do_op(32'h8000_0000, 16'hFFFF, 0);
      do_op(32'h8000_0000, 16'h8000, 0);
      do_op(32'h1234_5678, 16'h00AB, 10);

      // clear when the bit counter reads 5
      wait_ready();
      a = 32'd1000; b = 16'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (26) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_idle", {ir, ov}, {3'b111, 3'b000});
      chk("clear_keeps_result", {q_o[0], r_o[0]}, {eq[0], er[0]});
      saw_ov = 1'b0;
      repeat (40) begin @(negedge clk); saw_ov |= (ov != 3'b000); end
      chk("clear_no_out_valid", saw_ov, 1'b0);

      // asynchronous reset mid-calculation
      wait_ready();
      a = 32'd999; b = 16'd5; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", {ir, ov, dzo}, {3'b111, 3'b000, 3'b000});
      chk("async_rst_results", {q_o[2], r_o[2]}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_ov = 1'b0;
      repeat (40) begin @(negedge clk); saw_ov |= (ov != 3'b000); end
      chk("rst_no_out_valid", saw_ov, 1'b0);

      do_op(32'd9, 16'd3, 0);

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = 16'hFFFF;
            2:       rb = 16'h8000;
            3:       rb = BW'($urandom_range(1, 20));
            default: rb = BW'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         do_op(ra, rb, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
